// File: rtl/pipe_stage_skid_reg_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_skid_reg_if : valid/ready handshake bundle for a skid stage   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pipe_stage_skid_reg_if #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 68
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_skid_reg : 2-entry skid pipeline register with flush          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_stage_skid_reg #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 68
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  pipe_stage_skid_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic              ready_q;
  logic              valid_q;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              pop;

  assign accept = bus.in_valid & ready_q;
  assign pop    = valid_q & bus.out_ready;

  // Ready/valid are registered copies of the state so in_ready has no path from out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_ctrl <= bus.in_ctrl;
            main_data <= bus.in_data;
            state     <= ONE;
            valid_q   <= 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_ctrl <= bus.in_ctrl;
            main_data <= bus.in_data;
          end else if (accept) begin
            skid_ctrl <= bus.in_ctrl;
            skid_data <= bus.in_data;
            state     <= FULL;
            ready_q   <= 1'b0;
          end else if (pop) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            state     <= ONE;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_ctrl  = valid_q ? main_ctrl : '0;
  assign bus.out_data  = main_data;
  assign bus.occupancy = state;

endmodule
`default_nettype wire
